// File: rtl/alarm_if.sv
// Signal bundle between the timekeeping/user-input side and the alarm stage.
// master drives time and controls; slave (the alarm unit) returns alarm time and status.
interface alarm_if;
    logic       alarm_on;
    logic       set_mode;
    logic       btn_h;
    logic       btn_min;
    logic       btn_stop;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [5:0] al_hour;
    logic [5:0] al_minute;
    logic       ringing;
    logic       alarm_on_led;

    modport master (
        output alarm_on, set_mode, btn_h, btn_min, btn_stop, hour, minute, second,
        input  al_hour, al_minute, ringing, alarm_on_led
    );

    modport slave (
        input  alarm_on, set_mode, btn_h, btn_min, btn_stop, hour, minute, second,
        output al_hour, al_minute, ringing, alarm_on_led
    );
endinterface

// File: rtl/alarm_unit.sv
// Alarm stage: settable alarm time, match trigger on the live clock, bounded ring with snooze/stop.
// Buttons pass through a 2-FF synchroniser and a stable-count debouncer that emits a rise pulse.
module alarm_unit_deb #(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the accepted level
    always_comb begin
        sync_d  = {sync_q[0], btn};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync_q[1];
            else                              cnt_d   = cnt_q + CW'(1);
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;
endmodule

module alarm_unit #(
    parameter int DEB_CYCLES = 2_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input logic    clk,
    input logic    rst,
    alarm_if.slave a
);
    localparam int CMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    logic [2:0]    btn_raw, btn_p;
    logic          p_h, p_min, p_stop;
    logic [5:0]    al_hour_q, al_hour_d, al_minute_q, al_minute_d, sec_prev_q, sec_prev_d;
    logic          ringing_q, ringing_d, led_q, led_d;
    logic          sec_tick, trig;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign btn_raw = {a.btn_stop, a.btn_min, a.btn_h};

    alarm_unit_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [2:0] (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_raw),
        .pulse (btn_p)
    );

    assign p_h    = btn_p[0];
    assign p_min  = btn_p[1];
    assign p_stop = btn_p[2];

    assign sec_tick = (a.second != sec_prev_q);
    assign trig = sec_tick & a.alarm_on & ~a.set_mode & (a.hour == al_hour_q)
                & (a.minute == al_minute_q) & (a.second == 6'd0);

    always_comb begin
        al_hour_d   = al_hour_q;
        al_minute_d = al_minute_q;
        if (a.set_mode && p_h)   al_hour_d   = (al_hour_q == 6'd23)   ? 6'd0 : al_hour_q + 6'd1;
        if (a.set_mode && p_min) al_minute_d = (al_minute_q == 6'd59) ? 6'd0 : al_minute_q + 6'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = RING;
                    cnt_d   = '0;
                end
            end
            RING: begin
                if (p_stop) begin
                    state_d = IDLE;
                end else if (p_h || p_min) begin
                    state_d = SNOOZE;
                    cnt_d   = '0;
                end else if (sec_tick) begin
                    if (cnt_q + CW'(1) == CW'(RING_SEC)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SNOOZE: begin
                if (p_stop) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    if (cnt_q + CW'(1) == CW'(SNOOZE_SEC)) begin
                        state_d = RING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // disabling or editing the alarm overrides everything else
        if (!a.alarm_on || a.set_mode) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign ringing_d  = (state_q == RING);
    assign led_d      = a.alarm_on;
    assign sec_prev_d = a.second;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            al_hour_q   <= '0;
            al_minute_q <= '0;
            sec_prev_q  <= '0;
            ringing_q   <= 1'b0;
            led_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
        end else begin
            al_hour_q   <= al_hour_d;
            al_minute_q <= al_minute_d;
            sec_prev_q  <= sec_prev_d;
            ringing_q   <= ringing_d;
            led_q       <= led_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign a.al_hour      = al_hour_q;
    assign a.al_minute    = al_minute_q;
    assign a.ringing      = ringing_q;
    assign a.alarm_on_led = led_q;
endmodule
